// File: rtl/ring_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : ring_counter_n
//  Description : Parametrised ring / Johnson (twisted-ring) counter with
//                bidirectional stepping, cycle-position tracking, a wrap
//                pulse, and illegal-state detection with optional
//                self-correction.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH        counter width (>= 2)
//    SELF_CORRECT 1: an illegal state is replaced by the mode's reset pattern
//                    on the next enabled step; 0: it is only flagged
//    PW           width of pos, $clog2(2*WIDTH) (derived, not overridable)
//  Ports
//    clk      in   rising-edge clock
//    clr      in   synchronous active-high reset
//    en       in   step enable
//    load     in   parallel load of init and mode
//    dir      in   0 = shift toward MSB, 1 = shift toward LSB
//    johnson  in   mode latched on load (0 = ring, 1 = Johnson)
//    init     in   load value
//    count    out  counter state
//    pos      out  step index within the period, signed by direction
//    wrap     out  one-cycle pulse when pos wraps
//    err      out  count is illegal for the latched mode
// ============================================================================
module ring_counter_n #(
    parameter int WIDTH        = 4,
    parameter bit SELF_CORRECT = 1'b1,
    localparam int PW          = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic             dir,
    input  logic             johnson,
    input  logic [WIDTH-1:0] init,
    output logic [WIDTH-1:0] count,
    output logic [PW-1:0]    pos,
    output logic             wrap,
    output logic             err
);

    // Last pos value of each mode's period (P-1).
    localparam logic [PW-1:0] RING_LAST = PW'(WIDTH - 1);
    localparam logic [PW-1:0] JOHN_LAST = PW'(2 * WIDTH - 1);

    localparam logic [WIDTH-1:0] ONE_HOT_RESET = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pos_q,   pos_d;
    logic             wrap_q,  wrap_d;
    logic             err_q,   err_d;
    logic             jmode_q, jmode_d;

    logic [WIDTH-1:0] shifted;
    logic [PW-1:0]    last;

    // Ring: any nonzero value. Johnson: 0*1* or 1*0*. A value v is of the
    // form 0*1* exactly when v & (v+1) == 0 (including all-0 and all-1);
    // 1*0* is the same test applied to ~v.
    function automatic logic is_legal(input logic [WIDTH-1:0] v,
                                      input logic             jm);
        logic [WIDTH-1:0] nv;
        nv = ~v;
        if (jm) begin
            is_legal = ((v & (v + WIDTH'(1))) == '0) ||
                       ((nv & (nv + WIDTH'(1))) == '0);
        end else begin
            is_legal = (v != '0);
        end
    endfunction

    // Rotation; in Johnson mode the bit fed back is inverted.
    always_comb begin
        shifted = count_q;
        if (dir == 1'b0) begin
            shifted = {count_q[WIDTH-2:0], count_q[WIDTH-1] ^ jmode_q};
        end else begin
            shifted = {count_q[0] ^ jmode_q, count_q[WIDTH-1:1]};
        end
    end

    assign last = jmode_q ? JOHN_LAST : RING_LAST;

    always_comb begin
        count_d = count_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        jmode_d = jmode_q;

        if (clr) begin
            count_d = ONE_HOT_RESET;
            pos_d   = '0;
            err_d   = 1'b0;
            jmode_d = 1'b0;
        end else if (load) begin
            count_d = init;
            pos_d   = '0;
            err_d   = ~is_legal(init, johnson);
            jmode_d = johnson;
        end else if (en) begin
            if (err_q && SELF_CORRECT) begin
                count_d = jmode_q ? '0 : ONE_HOT_RESET;
                pos_d   = '0;
                err_d   = 1'b0;
            end else begin
                count_d = shifted;
                err_d   = ~is_legal(shifted, jmode_q);
                if (dir == 1'b0) begin
                    wrap_d = (pos_q == last);
                    pos_d  = (pos_q == last) ? '0 : pos_q + PW'(1);
                end else begin
                    wrap_d = (pos_q == '0);
                    pos_d  = (pos_q == '0) ? last : pos_q - PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= ONE_HOT_RESET;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            jmode_q <= 1'b0;
        end else begin
            count_q <= count_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            jmode_q <= jmode_d;
        end
    end

    assign count = count_q;
    assign pos   = pos_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_counter_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_counter_n
//  Description : Directed self-checking bench for ring_counter_n (WIDTH=4),
//                one instance with self-correction and one without.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_counter_n;

    logic       clk;
    logic       clr;
    logic       en;
    logic       load;
    logic       dir;
    logic       johnson;
    logic [3:0] init;

    logic [3:0] cnt_sc,  cnt_nc;
    logic [2:0] pos_sc,  pos_nc;
    logic       wrap_sc, wrap_nc;
    logic       err_sc,  err_nc;

    logic       sel_nc;
    logic [3:0] obs_cnt;
    logic [2:0] obs_pos;
    logic       obs_wrap;
    logic       obs_err;

    int n_checks;
    int n_fail;

    ring_counter_n #(.WIDTH(4), .SELF_CORRECT(1'b1)) dut_sc (
        .clk(clk), .clr(clr), .en(en), .load(load), .dir(dir),
        .johnson(johnson), .init(init),
        .count(cnt_sc), .pos(pos_sc), .wrap(wrap_sc), .err(err_sc)
    );

    ring_counter_n #(.WIDTH(4), .SELF_CORRECT(1'b0)) dut_nc (
        .clk(clk), .clr(clr), .en(en), .load(load), .dir(dir),
        .johnson(johnson), .init(init),
        .count(cnt_nc), .pos(pos_nc), .wrap(wrap_nc), .err(err_nc)
    );

    always_comb begin
        obs_cnt  = sel_nc ? cnt_nc  : cnt_sc;
        obs_pos  = sel_nc ? pos_nc  : pos_sc;
        obs_wrap = sel_nc ? wrap_nc : wrap_sc;
        obs_err  = sel_nc ? err_nc  : err_sc;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [3:0] c,
                                input int p, input logic w, input logic e);
        check_eq({tag, ".count"}, 32'(obs_cnt),  32'(c));
        check_eq({tag, ".pos"},   32'(obs_pos),  32'(p));
        check_eq({tag, ".wrap"},  32'(obs_wrap), 32'(w));
        check_eq({tag, ".err"},   32'(obs_err),  32'(e));
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] c;
        int         p;
        logic       w;
        logic       e;
    } exp_t;

    exp_t ring_fwd[4];
    exp_t john_fwd[8];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel_nc   = 1'b0;
        clr = 1'b1; en = 1'b0; load = 1'b0; dir = 1'b0; johnson = 1'b0;
        init = 4'b0000;

        // Reset state
        tick();
        expect_state("reset", 4'b0001, 0, 1'b0, 1'b0);

        // Ring, left rotation, one full period
        ring_fwd[0] = '{4'b0010, 1, 1'b0, 1'b0};
        ring_fwd[1] = '{4'b0100, 2, 1'b0, 1'b0};
        ring_fwd[2] = '{4'b1000, 3, 1'b0, 1'b0};
        ring_fwd[3] = '{4'b0001, 0, 1'b1, 1'b0};
        clr = 1'b0; en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_state($sformatf("ring_l%0d", i), ring_fwd[i].c,
                         ring_fwd[i].p, ring_fwd[i].w, ring_fwd[i].e);
        end
        en = 1'b0;
        tick();
        expect_state("ring_hold", 4'b0001, 0, 1'b0, 1'b0);

        // Ring load 1010, rotate right
        load = 1'b1; init = 4'b1010; johnson = 1'b0;
        tick();
        expect_state("ld1010", 4'b1010, 0, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; dir = 1'b1;
        tick();
        expect_state("ring_r0", 4'b0101, 3, 1'b1, 1'b0);
        tick();
        expect_state("ring_r1", 4'b1010, 2, 1'b0, 1'b0);
        tick();
        expect_state("ring_r2", 4'b0101, 1, 1'b0, 1'b0);
        en = 1'b0;
        tick();
        expect_state("ring_r_hold", 4'b0101, 1, 1'b0, 1'b0);

        // Johnson from 0000, full period, then reverse at 1111
        john_fwd[0] = '{4'b0001, 1, 1'b0, 1'b0};
        john_fwd[1] = '{4'b0011, 2, 1'b0, 1'b0};
        john_fwd[2] = '{4'b0111, 3, 1'b0, 1'b0};
        john_fwd[3] = '{4'b1111, 4, 1'b0, 1'b0};
        john_fwd[4] = '{4'b1110, 5, 1'b0, 1'b0};
        john_fwd[5] = '{4'b1100, 6, 1'b0, 1'b0};
        john_fwd[6] = '{4'b1000, 7, 1'b0, 1'b0};
        john_fwd[7] = '{4'b0000, 0, 1'b1, 1'b0};
        load = 1'b1; init = 4'b0000; johnson = 1'b1;
        tick();
        expect_state("ldj0000", 4'b0000, 0, 1'b0, 1'b0);
        load = 1'b0; johnson = 1'b0; en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_state($sformatf("john_l%0d", i), john_fwd[i].c,
                         john_fwd[i].p, john_fwd[i].w, john_fwd[i].e);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        expect_state("john_at1111", 4'b1111, 4, 1'b0, 1'b0);
        dir = 1'b1;
        tick();
        expect_state("john_rev", 4'b0111, 3, 1'b0, 1'b0);

        // Self-correction: illegal Johnson load, then one step
        en = 1'b0; dir = 1'b0;
        load = 1'b1; init = 4'b0101; johnson = 1'b1;
        tick();
        expect_state("sc_ldj0101", 4'b0101, 0, 1'b0, 1'b1);
        load = 1'b0; en = 1'b1;
        tick();
        expect_state("sc_jfix", 4'b0000, 0, 1'b0, 1'b0);

        // Self-correction: zero ring load, then one step
        en = 1'b0;
        load = 1'b1; init = 4'b0000; johnson = 1'b0;
        tick();
        expect_state("sc_ldr0000", 4'b0000, 0, 1'b0, 1'b1);
        load = 1'b0; en = 1'b1;
        tick();
        expect_state("sc_rfix", 4'b0001, 0, 1'b0, 1'b0);

        // No self-correction: zero ring keeps stepping pos, wrap once
        sel_nc = 1'b1;
        en = 1'b0;
        load = 1'b1; init = 4'b0000; johnson = 1'b0;
        tick();
        expect_state("nc_ld0000", 4'b0000, 0, 1'b0, 1'b1);
        load = 1'b0; en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_state($sformatf("nc_step%0d", i), 4'b0000, (i + 1) % 4,
                         (i == 3), 1'b1);
        end
        sel_nc = 1'b0;

        // Priority: clr over load and en; mode returns to ring
        clr = 1'b1; load = 1'b1; en = 1'b1; init = 4'b0110; johnson = 1'b1;
        tick();
        expect_state("pri_clr", 4'b0001, 0, 1'b0, 1'b0);
        clr = 1'b0; load = 1'b0; johnson = 1'b0;
        tick();
        expect_state("pri_ringmode", 4'b0010, 1, 1'b0, 1'b0);

        // Priority: load over en
        load = 1'b1; init = 4'b1100; johnson = 1'b1;
        tick();
        expect_state("pri_load", 4'b1100, 0, 1'b0, 1'b0);
        load = 1'b0; johnson = 1'b0;
        tick();
        expect_state("pri_j0", 4'b1000, 1, 1'b0, 1'b0);
        tick();
        expect_state("pri_j1", 4'b0000, 2, 1'b0, 1'b0);

        // clr mid-Johnson sequence
        clr = 1'b1;
        tick();
        expect_state("pri_midclr", 4'b0001, 0, 1'b0, 1'b0);
        clr = 1'b0;
        tick();
        expect_state("pri_postclr", 4'b0010, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
